// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Shares the single data port of the unified word-addressed memory between
//   two requesters: M0 (core load/store unit) and M1 (boot loader / debug
//   writer). One access is accepted per cycle under round-robin arbitration.
//   Read data is steered back to whichever requester issued the read, in
//   grant order.
//
// Parameters:
//   DEPTH       memory size in 32-bit words; addresses >= DEPTH are rejected
//   RD_LATENCY  cycles from the accepting posedge until mem_dout is valid
//
// Ports:
//   clock                 system clock, all state updates on posedge
//   reset                 synchronous, active-high
//   m0_req / m1_req       request; held with stable fields until granted
//   m0_rw / m1_rw         1 = write, 0 = read
//   m0_addr / m1_addr     word address
//   m0_wdata / m1_wdata   write data
//   m0_gnt / m1_gnt       combinational; the access is accepted this cycle
//   m0_rvalid / m1_rvalid registered; read response valid for one cycle
//   m0_rdata / m1_rdata   registered read data, holds while rvalid is low
//   m0_err / m1_err       registered; pulses in the response slot of an
//                         out-of-range access (read or write)
//   mem_rw                memory write enable
//   mem_ain               memory word address
//   mem_din               memory write data
//   mem_dout              memory read data, registered inside the memory
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int DEPTH      = 1024,
    parameter int RD_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        m0_req,
    input  logic        m0_rw,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,

    input  logic        m1_req,
    input  logic        m1_rw,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,

    output logic        mem_rw,
    output logic [31:0] mem_ain,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);

    // Identifies a requester; also used as the round-robin priority pointer.
    typedef enum logic {
        REQ_M0 = 1'b0,
        REQ_M1 = 1'b1
    } req_e;

    // One in-flight response slot. A slot is created for every granted
    // access that will produce a visible response: in-range reads, and any
    // out-of-range access (which reports err).
    typedef struct packed {
        logic valid;
        logic isRead;
        logic outOfRange;
        req_e owner;
    } pend_t;

    // Requester favoured when both ask in the same cycle.
    req_e         prio_q;

    // Last issued address/data, so the memory port is stable while idle.
    logic [31:0]  lastAin_q;
    logic [31:0]  lastDin_q;

    // Response slots travelling alongside the memory's read latency.
    pend_t        pend_q [RD_LATENCY];

    // Combinational arbitration results.
    logic         anyGrant;
    req_e         winner;
    logic         selRw;
    logic [31:0]  selAddr;
    logic [31:0]  selWdata;
    logic         inRange;
    pend_t        pend_d;
    pend_t        pendLast;

    // Arbitration and issue. Reset suppresses any grant so a requester never
    // believes an access was accepted while the state is being cleared.
    always_comb begin
        anyGrant = !reset && (m0_req || m1_req);

        winner = REQ_M0;
        if (m0_req && m1_req) begin
            winner = prio_q;
        end else if (m1_req) begin
            winner = REQ_M1;
        end

        selRw    = m0_rw;
        selAddr  = m0_addr;
        selWdata = m0_wdata;
        if (winner == REQ_M1) begin
            selRw    = m1_rw;
            selAddr  = m1_addr;
            selWdata = m1_wdata;
        end

        inRange = (selAddr < 32'(DEPTH));

        m0_gnt = anyGrant && (winner == REQ_M0);
        m1_gnt = anyGrant && (winner == REQ_M1);

        // Out-of-range accesses still drive the address bus but must never
        // write the memory.
        mem_rw  = anyGrant && selRw && inRange;
        mem_ain = anyGrant ? selAddr  : lastAin_q;
        mem_din = anyGrant ? selWdata : lastDin_q;

        pend_d.valid      = anyGrant && (!selRw || !inRange);
        pend_d.isRead     = !selRw;
        pend_d.outOfRange = !inRange;
        pend_d.owner      = winner;

        pendLast = pend_q[RD_LATENCY-1];
    end

    // Priority pointer, idle hold registers, response pipeline and the
    // registered per-requester response outputs. The response stage samples
    // mem_dout in the same cycle the oldest slot matures, which places rvalid
    // two edges after the grant cycle for RD_LATENCY = 1. Reset empties the
    // pipeline, so a read caught mid-flight never produces a response.
    always_ff @(posedge clock) begin
        if (reset) begin
            prio_q    <= REQ_M0;
            lastAin_q <= '0;
            lastDin_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pend_q[i] <= '0;
            end
            m0_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m0_err    <= 1'b0;
            m1_rvalid <= 1'b0;
            m1_rdata  <= '0;
            m1_err    <= 1'b0;
        end else begin
            // Whoever wins, the other side is favoured next time.
            if (anyGrant) begin
                prio_q    <= (winner == REQ_M0) ? REQ_M1 : REQ_M0;
                lastAin_q <= selAddr;
                lastDin_q <= selWdata;
            end

            pend_q[0] <= pend_d;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pend_q[i] <= pend_q[i-1];
            end

            m0_rvalid <= pendLast.valid && pendLast.isRead && (pendLast.owner == REQ_M0);
            m1_rvalid <= pendLast.valid && pendLast.isRead && (pendLast.owner == REQ_M1);
            m0_err    <= pendLast.valid && pendLast.outOfRange && (pendLast.owner == REQ_M0);
            m1_err    <= pendLast.valid && pendLast.outOfRange && (pendLast.owner == REQ_M1);

            // Out-of-range reads return zero instead of whatever the memory
            // happens to present; rdata is untouched when no read returns.
            if (pendLast.valid && pendLast.isRead && (pendLast.owner == REQ_M0)) begin
                m0_rdata <= pendLast.outOfRange ? 32'h0 : mem_dout;
            end
            if (pendLast.valid && pendLast.isRead && (pendLast.owner == REQ_M1)) begin
                m1_rdata <= pendLast.outOfRange ? 32'h0 : mem_dout;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed testbench for mem_arbiter. A small behavioural memory with one
// cycle of registered read latency sits on the memory data port. Each task
// drives one scenario and checks the arbiter's outputs against hand-computed
// values.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clock;
    logic        reset;
    logic        m0_req, m0_rw, m0_gnt, m0_rvalid, m0_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_rw, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        mem_rw;
    logic [31:0] mem_ain, mem_din, mem_dout;

    int checksTotal  = 0;
    int checksPassed = 0;

    logic [31:0] memArray [0:1023];

    mem_arbiter #(.DEPTH(1024), .RD_LATENCY(1)) dut (
        .clock     (clock),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_rw     (m0_rw),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m0_err    (m0_err),
        .m1_req    (m1_req),
        .m1_rw     (m1_rw),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .m1_err    (m1_err),
        .mem_rw    (mem_rw),
        .mem_ain   (mem_ain),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    // 100 MHz-style clock, period 10.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Behavioural memory: writes commit at the edge, read data is registered
    // and valid one cycle after the address is issued.
    always @(posedge clock) begin
        if (mem_rw) memArray[mem_ain[9:0]] <= mem_din;
        mem_dout <= memArray[mem_ain[9:0]];
    end

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        m0_req = 1'b1; m0_rw = 1'b0; m0_addr = 32'd7; m0_wdata = 32'h1234;
        m1_req = 1'b0; m1_rw = 1'b0; m1_addr = 32'd0; m1_wdata = 32'h0;
        step();
        #1;
        checksTotal++; if (m0_gnt !== 1'b0) $display("[TB] FAIL rst_gnt_during: got %b expected 0", m0_gnt); else checksPassed++;
        checksTotal++; if (mem_rw !== 1'b0) $display("[TB] FAIL rst_memrw_during: got %b expected 0", mem_rw); else checksPassed++;
        m0_req = 1'b0;
        step();
        reset = 1'b0;
        #1;
        checksTotal++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) $display("[TB] FAIL rst_rvalid: got %b%b expected 00", m0_rvalid, m1_rvalid); else checksPassed++;
        checksTotal++; if (m0_rdata !== 32'h0) $display("[TB] FAIL rst_m0_rdata: got %h expected 0", m0_rdata); else checksPassed++;
        checksTotal++; if (m1_rdata !== 32'h0) $display("[TB] FAIL rst_m1_rdata: got %h expected 0", m1_rdata); else checksPassed++;
        checksTotal++; if (m0_err !== 1'b0 || m1_err !== 1'b0) $display("[TB] FAIL rst_err: got %b%b expected 00", m0_err, m1_err); else checksPassed++;
        checksTotal++; if (mem_ain !== 32'h0 || mem_din !== 32'h0) $display("[TB] FAIL rst_mem_bus: got %h/%h expected 0/0", mem_ain, mem_din); else checksPassed++;
        checksTotal++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0 || mem_rw !== 1'b0) $display("[TB] FAIL rst_idle: got gnt %b%b rw %b expected 000", m0_gnt, m1_gnt, mem_rw); else checksPassed++;
    endtask

    task automatic test_write_read();
        // Write cycle
        m0_req = 1'b1; m0_rw = 1'b1; m0_addr = 32'd5; m0_wdata = 32'hDEADBEEF;
        #1;
        checksTotal++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) $display("[TB] FAIL wr_gnt: got %b%b expected 10", m0_gnt, m1_gnt); else checksPassed++;
        checksTotal++; if (mem_rw !== 1'b1) $display("[TB] FAIL wr_memrw: got %b expected 1", mem_rw); else checksPassed++;
        checksTotal++; if (mem_ain !== 32'd5 || mem_din !== 32'hDEADBEEF) $display("[TB] FAIL wr_bus: got %h/%h expected 5/deadbeef", mem_ain, mem_din); else checksPassed++;
        step();
        // Read cycle
        m0_rw = 1'b0;
        #1;
        checksTotal++; if (m0_gnt !== 1'b1) $display("[TB] FAIL rd_gnt: got %b expected 1", m0_gnt); else checksPassed++;
        checksTotal++; if (mem_rw !== 1'b0 || mem_ain !== 32'd5) $display("[TB] FAIL rd_issue: got rw %b ain %h expected 0/5", mem_rw, mem_ain); else checksPassed++;
        step();
        m0_req = 1'b0;
        #1;
        // Write response slot: writes never raise rvalid
        checksTotal++; if (m0_rvalid !== 1'b0 || m0_gnt !== 1'b0) $display("[TB] FAIL wr_no_rvalid: got rvalid %b gnt %b expected 0/0", m0_rvalid, m0_gnt); else checksPassed++;
        step();
        #1;
        checksTotal++; if (m0_rvalid !== 1'b1) $display("[TB] FAIL rd_rvalid: got %b expected 1", m0_rvalid); else checksPassed++;
        checksTotal++; if (m0_rdata !== 32'hDEADBEEF) $display("[TB] FAIL rd_rdata: got %h expected deadbeef", m0_rdata); else checksPassed++;
        checksTotal++; if (m1_rvalid !== 1'b0 || m0_err !== 1'b0) $display("[TB] FAIL rd_other: got m1_rvalid %b m0_err %b expected 0/0", m1_rvalid, m0_err); else checksPassed++;
        step();
        #1;
        checksTotal++; if (m0_rvalid !== 1'b0 || m0_rdata !== 32'hDEADBEEF) $display("[TB] FAIL rd_hold: got %b/%h expected 0/deadbeef", m0_rvalid, m0_rdata); else checksPassed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] expData [3];
        expData[0] = 32'h11; expData[1] = 32'h22; expData[2] = 32'h33;
        // Boot loader writes 1..3, then reads them back on consecutive cycles.
        for (int i = 0; i < 9; i++) begin
            m1_req   = (i < 6);
            m1_rw    = (i < 3);
            m1_addr  = 32'((i % 3) + 1);
            m1_wdata = (i < 3) ? expData[i] : 32'h0;
            #1;
            if (i < 6) begin
                checksTotal++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) $display("[TB] FAIL b2b_gnt[%0d]: got %b%b expected 01", i, m0_gnt, m1_gnt); else checksPassed++;
            end
            if (i >= 5 && i <= 7) begin
                checksTotal++; if (m1_rvalid !== 1'b1 || m1_rdata !== expData[i-5]) $display("[TB] FAIL b2b_resp[%0d]: got %b/%h expected 1/%h", i, m1_rvalid, m1_rdata, expData[i-5]); else checksPassed++;
            end else begin
                checksTotal++; if (m1_rvalid !== 1'b0) $display("[TB] FAIL b2b_norvalid[%0d]: got %b expected 0", i, m1_rvalid); else checksPassed++;
            end
            checksTotal++; if (m0_rvalid !== 1'b0) $display("[TB] FAIL b2b_m0_quiet[%0d]: got %b expected 0", i, m0_rvalid); else checksPassed++;
            step();
        end
    endtask

    task automatic test_round_robin();
        reset = 1'b1;
        step();
        reset = 1'b0;
        // M0 reads addr 5 (0xDEADBEEF), M1 reads addr 2 (0x22), both held.
        m0_req = 1'b1; m0_rw = 1'b0; m0_addr = 32'd5;
        m1_req = 1'b1; m1_rw = 1'b0; m1_addr = 32'd2;
        for (int i = 0; i < 8; i++) begin
            if (i >= 6) begin
                m0_req = 1'b0; m1_req = 1'b0;
            end
            #1;
            if (i < 6) begin
                checksTotal++; if (m0_gnt !== (i % 2 == 0) || m1_gnt !== (i % 2 == 1)) $display("[TB] FAIL rr_gnt[%0d]: got %b%b expected %b%b", i, m0_gnt, m1_gnt, (i % 2 == 0), (i % 2 == 1)); else checksPassed++;
            end
            if (i >= 2) begin
                checksTotal++; if (m0_rvalid !== (i % 2 == 0) || m1_rvalid !== (i % 2 == 1)) $display("[TB] FAIL rr_rvalid[%0d]: got %b%b expected %b%b", i, m0_rvalid, m1_rvalid, (i % 2 == 0), (i % 2 == 1)); else checksPassed++;
                if (i % 2 == 0) begin
                    checksTotal++; if (m0_rdata !== 32'hDEADBEEF) $display("[TB] FAIL rr_m0_rdata[%0d]: got %h expected deadbeef", i, m0_rdata); else checksPassed++;
                end else begin
                    checksTotal++; if (m1_rdata !== 32'h22) $display("[TB] FAIL rr_m1_rdata[%0d]: got %h expected 00000022", i, m1_rdata); else checksPassed++;
                end
            end
            step();
        end
    endtask

    task automatic test_out_of_range();
        m0_req = 1'b1; m0_rw = 1'b1; m0_addr = 32'd1024; m0_wdata = 32'hCAFEF00D;
        #1;
        checksTotal++; if (m0_gnt !== 1'b1 || mem_rw !== 1'b0) $display("[TB] FAIL oor_wr_issue: got gnt %b rw %b expected 1/0", m0_gnt, mem_rw); else checksPassed++;
        checksTotal++; if (mem_ain !== 32'd1024) $display("[TB] FAIL oor_wr_ain: got %h expected 400", mem_ain); else checksPassed++;
        step();
        m0_rw = 1'b0; m0_addr = 32'd4000;
        #1;
        checksTotal++; if (m0_gnt !== 1'b1 || mem_rw !== 1'b0) $display("[TB] FAIL oor_rd_issue: got gnt %b rw %b expected 1/0", m0_gnt, mem_rw); else checksPassed++;
        checksTotal++; if (m0_err !== 1'b0) $display("[TB] FAIL oor_err_early: got %b expected 0", m0_err); else checksPassed++;
        step();
        m0_req = 1'b0;
        #1;
        checksTotal++; if (m0_err !== 1'b1 || m0_rvalid !== 1'b0) $display("[TB] FAIL oor_wr_resp: got err %b rvalid %b expected 1/0", m0_err, m0_rvalid); else checksPassed++;
        checksTotal++; if (mem_rw !== 1'b0) $display("[TB] FAIL oor_memrw_idle: got %b expected 0", mem_rw); else checksPassed++;
        step();
        #1;
        checksTotal++; if (m0_err !== 1'b1 || m0_rvalid !== 1'b1) $display("[TB] FAIL oor_rd_resp: got err %b rvalid %b expected 1/1", m0_err, m0_rvalid); else checksPassed++;
        checksTotal++; if (m0_rdata !== 32'h0) $display("[TB] FAIL oor_rd_rdata: got %h expected 0", m0_rdata); else checksPassed++;
        checksTotal++; if (m1_err !== 1'b0 || m1_rvalid !== 1'b0) $display("[TB] FAIL oor_other: got err %b rvalid %b expected 0/0", m1_err, m1_rvalid); else checksPassed++;
        step();
        #1;
        checksTotal++; if (m0_err !== 1'b0 || m0_rvalid !== 1'b0) $display("[TB] FAIL oor_end: got err %b rvalid %b expected 0/0", m0_err, m0_rvalid); else checksPassed++;
    endtask

    task automatic test_reset_mid_read();
        // M0 read granted; prio now favours M1.
        m0_req = 1'b1; m0_rw = 1'b0; m0_addr = 32'd5; m0_wdata = 32'h0;
        #1;
        checksTotal++; if (m0_gnt !== 1'b1) $display("[TB] FAIL rmr_gnt: got %b expected 1", m0_gnt); else checksPassed++;
        step();
        m0_req = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        checksTotal++; if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h0) $display("[TB] FAIL rmr_dropped: got %b/%h expected 0/0", m0_rvalid, m0_rdata); else checksPassed++;
        checksTotal++; if (mem_ain !== 32'h0 || mem_din !== 32'h0 || m0_err !== 1'b0) $display("[TB] FAIL rmr_reset_vals: got %h/%h err %b expected 0/0/0", mem_ain, mem_din, m0_err); else checksPassed++;
        step();
        // First contention after reset: M0 must win.
        m0_req = 1'b1; m1_req = 1'b1; m1_rw = 1'b0; m1_addr = 32'd3; m1_wdata = 32'h55;
        #1;
        checksTotal++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) $display("[TB] FAIL rmr_prio: got %b%b expected 10", m0_gnt, m1_gnt); else checksPassed++;
        checksTotal++; if (m0_rvalid !== 1'b0) $display("[TB] FAIL rmr_no_late_rvalid: got %b expected 0", m0_rvalid); else checksPassed++;
        step();
        m0_req = 1'b0;
        #1;
        checksTotal++; if (m1_gnt !== 1'b1 || mem_ain !== 32'd3 || mem_din !== 32'h55) $display("[TB] FAIL rmr_m1_turn: got gnt %b ain %h din %h expected 1/3/55", m1_gnt, mem_ain, mem_din); else checksPassed++;
        step();
        m1_req = 1'b0;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            #1;
            checksTotal++; if (mem_rw !== 1'b0 || m0_gnt !== 1'b0 || m1_gnt !== 1'b0) $display("[TB] FAIL idle_quiet[%0d]: got rw %b gnt %b%b expected 0/00", i, mem_rw, m0_gnt, m1_gnt); else checksPassed++;
            checksTotal++; if (mem_ain !== 32'd3 || mem_din !== 32'h55) $display("[TB] FAIL idle_hold[%0d]: got %h/%h expected 3/55", i, mem_ain, mem_din); else checksPassed++;
            step();
        end
    endtask

    initial begin
        reset = 1'b1;
        m0_req = 1'b0; m0_rw = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_rw = 1'b0; m1_addr = '0; m1_wdata = '0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_round_robin();
        test_out_of_range();
        test_reset_mid_read();
        test_idle();
        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
